// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared types and constants for the seconds countdown engine.
//   - state_e      : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   - COUNT_W      : default width of the count and load value
//   - TICK_DIV_DEF : default system clock cycles per one-second tick
package countdown_timer_pkg;

    localparam int COUNT_W      = 5;
    localparam int TICK_DIV_DEF = 50000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler
//   Modulo-TICK_DIV cycle counter producing the one-second tick and the
//   half-second blink phase.
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset (count=0, half=1)
//     clr_i  in   synchronous clear to count 0 / half 1 (wins over en_i)
//     en_i   in   advance the counter this cycle; low holds everything
//     tick_o out  counter sits at its terminal value (TICK_DIV-1); the
//                 consumer qualifies it with its own enable so that no
//                 combinational path runs from en_i back to tick_o
//     half_o out  registered (count < TICK_DIV/2)
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic half_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;

    assign tick_o = (cnt_q == LAST);
    assign half_o = half_q;

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (clr_i) begin
            cnt_d  = '0;
            half_d = 1'b1;
        end else if (en_i) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
            // Blink tracks the value the counter is about to hold, so it
            // changes on the same edge as the counter.
            half_d = (cnt_d < HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            half_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   Seconds countdown engine feeding the two-digit 7-segment display stage.
//   Ports:
//     clk      in   system clock, rising edge
//     rst_n    in   synchronous active-low reset
//     start    in   pulse: load load_val and begin counting
//     pause    in   level: freeze count and prescaler while high
//     clear    in   pulse: abort to IDLE
//     load_val in   initial seconds value, sampled on the start cycle
//     count    out  remaining seconds (registered)
//     blink    out  1 in first half of each second, 0 in second half
//     show     out  display enable (every state except IDLE)
//     done     out  one-cycle pulse when count reaches 0
//   Control priority each cycle: clear > start > pause > tick.
module countdown_timer #(
    parameter int TICK_DIV = countdown_timer_pkg::TICK_DIV_DEF,
    parameter int COUNT_W  = countdown_timer_pkg::COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] count,
    output logic               blink,
    output logic               show,
    output logic               done
);

    import countdown_timer_pkg::*;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q, done_d;
    logic               presc_clr, presc_en, presc_tick;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (presc_clr),
        .en_i   (presc_en),
        .tick_o (presc_tick),
        .half_o (blink)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            count_d   = '0;
            presc_clr = 1'b1;
        end else if (start) begin
            presc_clr = 1'b1;
            count_d   = load_val;
            if (load_val == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: presc_clr = 1'b1;
                // PAUSE with pause released behaves as a RUN cycle, so the
                // total stall equals exactly the number of paused cycles.
                RUN, PAUSE: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else begin
                        state_d  = RUN;
                        presc_en = 1'b1;
                        if (presc_tick && count_q != '0) begin
                            count_d = count_q - COUNT_W'(1);
                            if (count_q == COUNT_W'(1)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                // Prescaler free-runs so the display keeps flashing "00".
                DONE: begin
                    presc_en = 1'b1;
                    count_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign show  = (state_q != IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [CW-1:0] count;
    logic          blink, show, done;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.TICK_DIV(TD), .COUNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load_val (load_val),
        .count    (count),
        .blink    (blink),
        .show     (show),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: modes 0=idle 1=running 2=paused 3=expired,
    // phase = cycles elapsed within the current second.
    int m_mode = 0, m_count = 0, m_phase = 0, m_done = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_mode = 0; m_count = 0; m_phase = 0; m_done = 0;
            end else if (clear) begin
                m_mode = 0; m_count = 0; m_phase = 0; m_done = 0;
            end else if (start) begin
                m_phase = 0;
                m_count = int'(load_val);
                m_mode  = (load_val == 0) ? 3 : 1;
                m_done  = (load_val == 0) ? 1 : 0;
            end else begin
                m_done = 0;
                case (m_mode)
                    0: m_phase = 0;
                    1, 2: begin
                        if (pause) m_mode = 2;
                        else begin
                            m_mode  = 1;
                            m_phase = m_phase + 1;
                            if (m_phase == TD) begin
                                m_phase = 0;
                                m_count = m_count - 1;
                                if (m_count == 0) begin
                                    m_mode = 3;
                                    m_done = 1;
                                end
                            end
                        end
                    end
                    default: begin
                        m_phase = (m_phase + 1) % TD;
                        m_count = 0;
                    end
                endcase
            end
            @(negedge clk);
            chk("model_count", 32'(count), 32'(m_count));
            chk("model_blink", 32'(blink), 32'(m_phase < TD / 2));
            chk("model_show",  32'(show),  32'(m_mode != 0));
            chk("model_done",  32'(done),  32'(m_done));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int v);
        load_val = CW'(v);
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    initial begin
        int edges;
        bit found;

        // 1. Reset with random inputs, then hold with no start.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); pause = 1'($urandom);
            clear = 1'($urandom); load_val = CW'($urandom);
            step(1);
        end
        chk("rst_count", 32'(count), 0);
        chk("rst_show",  32'(show), 0);
        chk("rst_blink", 32'(blink), 1);
        chk("rst_done",  32'(done), 0);
        rst_n = 1'b1; start = 0; pause = 0; clear = 0; load_val = '0;
        step(3);
        chk("idle_hold_count", 32'(count), 0);
        chk("idle_hold_show",  32'(show), 0);
        chk("idle_hold_blink", 32'(blink), 1);

        // 2. Normal run from 3: count drops every 4 edges, 0 at edge 12.
        pulse_start(3);
        chk("run_load", 32'(count), 3);
        chk("run_show", 32'(show), 1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("run_count", 32'(count), 32'(3 - k / 4));
            chk("run_blink", 32'(blink), 32'((k % 4) < 2));
            chk("run_done",  32'(done), 32'(k == 12));
            chk("run_show",  32'(show), 1);
        end
        step(1);
        chk("run_done_once", 32'(done), 0);

        // 3. Pause for 10 cycles with prescaler at 1: expiry at edge 30.
        pulse_start(5);
        step(1);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("pause_count", 32'(count), 5);
            chk("pause_blink", 32'(blink), 1);
        end
        pause = 1'b0;
        edges = 11;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            edges++;
            if (done) found = 1;
        end
        chk("pause_expiry_found", 32'(found), 1);
        chk("pause_expiry_edge", 32'(edges), 30);

        // 4. Zero load: straight to DONE, blink keeps toggling.
        pulse_start(0);
        chk("zero_done",  32'(done), 1);
        chk("zero_count", 32'(count), 0);
        chk("zero_show",  32'(show), 1);
        chk("zero_blink", 32'(blink), 1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("zero_blink_seq", 32'(blink), 32'((k % 4) < 2));
            chk("zero_done_low",  32'(done), 0);
        end

        // 5. Restart mid-run at count 2 with 17.
        clear = 1'b1; step(1); clear = 1'b0;
        chk("clear_show", 32'(show), 0);
        pulse_start(4);
        step(8);
        chk("restart_pre", 32'(count), 2);
        pulse_start(17);
        chk("restart_count", 32'(count), 17);
        chk("restart_done",  32'(done), 0);
        chk("restart_blink", 32'(blink), 1);
        step(1);
        chk("restart_hold", 32'(count), 17);

        // 6. Priority: clear beats start; pause beats a coincident tick.
        clear = 1'b1; start = 1'b1; load_val = CW'(9);
        step(1);
        clear = 1'b0; start = 1'b0;
        chk("clr_start_count", 32'(count), 0);
        chk("clr_start_show",  32'(show), 0);
        pulse_start(2);
        step(3);
        pause = 1'b1;
        step(1);
        chk("pause_tick_count", 32'(count), 2);
        pause = 1'b0;
        step(1);
        chk("resume_tick_count", 32'(count), 1);
        chk("resume_tick_blink", 32'(blink), 1);

        // 7. Maximum load accepted unmodified; reset mid-run.
        pulse_start(31);
        chk("max_load", 32'(count), 31);
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("midrun_rst_count", 32'(count), 0);
        chk("midrun_rst_show",  32'(show), 0);
        chk("midrun_rst_blink", 32'(blink), 1);
        rst_n = 1'b1;
        step(2);
        chk("post_rst_show", 32'(show), 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
